btn_event_decoder: RTL and testbench
====================================

Name: btn_event_decoder

Overview:
Consumes the steady-state level from the button debouncer and turns it into discrete user events.
- Events: press/release edges, single click, double click, long press, plus a running press count.
- Sits directly downstream of the debouncer; feeds LED/UI control logic.
- Input must already be synchronized and debounced; this block adds no synchronizer.

Parameters:
LONG_TIME, 24'd12_000_000, cycles a press must be held (counted from press detection) to raise a long-press event; legal range 2..2^24-1
DCLICK_TIME, 24'd3_000_000, cycles after a short release within which a second press makes a double click; legal range 2..2^24-1

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_debounced  input  1  debounced button level (1 = pressed)
o_press  output  1  one-cycle pulse on each press edge
o_release  output  1  one-cycle pulse on each release edge
o_click  output  1  one-cycle pulse, short press not followed by a second press within DCLICK_TIME
o_dclick  output  1  one-cycle pulse, second short press released
o_long  output  1  one-cycle pulse when a press reaches LONG_TIME
o_count  output  8  number of presses since reset, mod 256

Behaviour:
- Reset (i_reset_n=0, async assert, sync-style release on i_clk):
  - all outputs 0, o_count=0
  - edge register r_last=0, timer=0, state=IDLE
- Edge detect:
  - press = i_debounced & ~r_last; release = ~i_debounced & r_last; r_last <= i_debounced every cycle.
- Edge outputs:
  - o_press/o_release are registered: high for exactly one cycle, in the cycle after the clock edge that samples the new level.
  - o_count increments on that same edge; 255 wraps to 0.
- Timer: 24-bit, cleared to 0 on every state entry, +1 per cycle while in PRESSED, WAIT2 or PRESS2; never wraps, because each state exits at its limit.
- All event outputs (o_click, o_dclick, o_long) are registered one-cycle pulses, asserted in the cycle after the triggering edge/condition. At most one event pulse per cycle.
- FSM states: IDLE, PRESSED, LONG_HELD, WAIT2, PRESS2.
  - IDLE: press -> PRESSED.
  - PRESSED:
    - release while timer < LONG_TIME-1 -> WAIT2.
    - timer == LONG_TIME-1 with no release -> pulse o_long, -> LONG_HELD.
    - Release on the same cycle the limit is reached: release wins, no o_long.
  - LONG_HELD: release -> IDLE, no click event.
  - WAIT2:
    - press -> PRESS2.
    - timer == DCLICK_TIME-1 with no press -> pulse o_click, -> IDLE.
    - Press on the same cycle as the timeout: press wins, no o_click.
  - PRESS2:
    - release before the limit -> pulse o_dclick, -> IDLE.
    - timer == LONG_TIME-1 -> pulse o_long, -> LONG_HELD; no o_dclick, and the earlier first click is discarded.
- Reset mid-operation: any state aborts immediately to IDLE with no event pulse. If the button is held through reset release, r_last=0 makes the first sampled 1 a press.
- A third press after a double click starts a fresh sequence from IDLE.

Test Plan:
(Benches use LONG_TIME=16, DCLICK_TIME=8.)
1. Reset release, i_debounced=0 for 20 cycles -> all outputs 0, o_count=0.
2. Hold i_debounced=1 for 5 cycles, release, idle 10 cycles ->
   - o_press 1 cycle, o_release 1 cycle;
   - o_click pulses exactly once, 8 cycles after release detection;
   - o_count=1; no o_dclick, no o_long.
3. Press 4 cycles, release 3 cycles, press 4 cycles, release ->
   - o_dclick single pulse after the second release;
   - no o_click; o_count=2.
4. Hold 30 cycles ->
   - o_long single pulse 16 cycles after press detection;
   - release gives o_release only, no click; o_count=1.
5. Boundary checks ->
   - Release exactly when the PRESSED timer reaches 15: no o_long, click path taken.
   - Second press exactly when the WAIT2 timer reaches 7: PRESS2 entered, no o_click.
6. Drive 256 short presses spaced >8 cycles apart -> o_count wraps to 0. Then assert i_reset_n=0 mid-PRESSED -> outputs clear asynchronously and no event is emitted after release.

Source files
------------

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into press/release edges, click, double-click,
// long-press pulses and a running press counter.
module btn_event_decoder #(
  parameter logic [23:0] LONG_TIME   = 24'd12_000_000,
  parameter logic [23:0] DCLICK_TIME = 24'd3_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_debounced,
  output logic       o_press,
  output logic       o_release,
  output logic       o_click,
  output logic       o_dclick,
  output logic       o_long,
  output logic [7:0] o_count
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT2,
    PRESS2
  } state_t;

  localparam logic [23:0] LONG_LIMIT   = LONG_TIME - 24'd1;
  localparam logic [23:0] DCLICK_LIMIT = DCLICK_TIME - 24'd1;

  state_t      state_reg, state_next;
  logic [23:0] timer_reg, timer_next;
  logic        last_reg;
  logic        press_edge, release_edge;
  logic        click_next, dclick_next, long_next;

  assign press_edge   = i_debounced & ~last_reg;
  assign release_edge = ~i_debounced & last_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_reg  <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_count   <= 8'd0;
    end else begin
      last_reg  <= i_debounced;
      o_press   <= press_edge;
      o_release <= release_edge;
      o_count   <= o_count + {7'd0, press_edge};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= IDLE;
      timer_reg <= 24'd0;
      o_click   <= 1'b0;
      o_dclick  <= 1'b0;
      o_long    <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      o_click   <= click_next;
      o_dclick  <= dclick_next;
      o_long    <= long_next;
    end
  end

  // Edges take priority over the timer limit in every timed state.
  always_comb begin
    state_next  = state_reg;
    click_next  = 1'b0;
    dclick_next = 1'b0;
    long_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (press_edge) state_next = PRESSED;
      end
      PRESSED: begin
        if (release_edge) begin
          state_next = WAIT2;
        end else if (timer_reg == LONG_LIMIT) begin
          long_next  = 1'b1;
          state_next = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (release_edge) state_next = IDLE;
      end
      WAIT2: begin
        if (press_edge) begin
          state_next = PRESS2;
        end else if (timer_reg == DCLICK_LIMIT) begin
          click_next = 1'b1;
          state_next = IDLE;
        end
      end
      PRESS2: begin
        if (release_edge) begin
          dclick_next = 1'b1;
          state_next  = IDLE;
        end else if (timer_reg == LONG_LIMIT) begin
          long_next  = 1'b1;
          state_next = LONG_HELD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Timer restarts on every state entry and only runs in the timed states.
  always_comb begin
    timer_next = 24'd0;
    if (state_next == state_reg &&
        (state_reg == PRESSED || state_reg == WAIT2 || state_reg == PRESS2)) begin
      timer_next = timer_reg + 24'd1;
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Randomized and directed bench for btn_event_decoder, compared cycle by cycle
// against a timestamp-based reference model of the button event rules.
module tb_btn_event_decoder;

  localparam int L = 16;
  localparam int D = 8;

  logic       i_clk;
  logic       i_reset_n;
  logic       i_debounced;
  logic       o_press, o_release, o_click, o_dclick, o_long;
  logic [7:0] o_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model: sequence bookkeeping by edge timestamps
  logic m_prev;
  int   m_count;
  bit   m_active, m_wait, m_long_done;
  int   m_seq, m_mark;
  logic e_press, e_release, e_click, e_dclick, e_long;

  int n_press, n_release, n_click, n_dclick, n_long;
  int t_press, t_release, t_click, t_long;

  btn_event_decoder #(
    .LONG_TIME  (24'd16),
    .DCLICK_TIME(24'd8)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_debounced(i_debounced),
    .o_press    (o_press),
    .o_release  (o_release),
    .o_click    (o_click),
    .o_dclick   (o_dclick),
    .o_long     (o_long),
    .o_count    (o_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b0; m_count = 0;
    m_active = 0; m_wait = 0; m_long_done = 0; m_seq = 0; m_mark = 0;
    e_press = 0; e_release = 0; e_click = 0; e_dclick = 0; e_long = 0;
  endtask

  task automatic model_update(input logic lvl);
    e_press   = lvl & ~m_prev;
    e_release = ~lvl & m_prev;
    e_click = 0; e_dclick = 0; e_long = 0;
    m_prev = lvl;
    if (e_press) m_count = (m_count + 1) % 256;
    if (!m_active) begin
      if (e_press) begin
        m_active = 1; m_seq = 1; m_wait = 0; m_long_done = 0; m_mark = cyc;
      end
    end else if (m_wait) begin
      if (e_press) begin
        m_seq = 2; m_wait = 0; m_mark = cyc;
      end else if (cyc - m_mark == D) begin
        e_click = 1; m_active = 0;
      end
    end else begin
      if (e_release) begin
        if (m_long_done) m_active = 0;
        else if (m_seq == 1) begin m_wait = 1; m_mark = cyc; end
        else begin e_dclick = 1; m_active = 0; end
      end else if (!m_long_done && cyc - m_mark == L) begin
        e_long = 1; m_long_done = 1;
      end
    end
  endtask

  task automatic clear_obs();
    n_press = 0; n_release = 0; n_click = 0; n_dclick = 0; n_long = 0;
    t_press = 0; t_release = 0; t_click = 0; t_long = 0;
  endtask

  // one clock: drive level, let the DUT sample it, compare after the edge
  task automatic step(input logic lvl);
    logic [12:0] obs, exp;
    i_debounced = lvl;
    @(posedge i_clk);
    cyc++;
    model_update(lvl);
    @(negedge i_clk);
    obs = {o_press, o_release, o_click, o_dclick, o_long, o_count};
    exp = {e_press, e_release, e_click, e_dclick, e_long, 8'(m_count)};
    check($sformatf("cyc%0d", cyc), 32'(obs), 32'(exp));
    if (o_press)   begin n_press++;   t_press = cyc;   end
    if (o_release) begin n_release++; t_release = cyc; end
    if (o_click)   begin n_click++;   t_click = cyc;   end
    if (o_dclick)  begin n_dclick++;  end
    if (o_long)    begin n_long++;    t_long = cyc;    end
  endtask

  task automatic hold(input logic lvl, input int n);
    for (int k = 0; k < n; k++) step(lvl);
  endtask

  // called just after a falling edge; reset asserts mid-cycle
  task automatic do_reset(input logic lvl);
    i_debounced = lvl;
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_async", 32'({o_press, o_release, o_click, o_dclick, o_long, o_count}), 32'd0);
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    logic lvl;
    int dur;
    i_reset_n = 1'b0;
    i_debounced = 1'b0;
    model_reset();
    clear_obs();
    @(negedge i_clk);
    do_reset(1'b0);

    // idle after reset
    hold(1'b0, 20);
    check("t1_events", 32'(n_press + n_release + n_click + n_dclick + n_long), 32'd0);
    check("t1_count", 32'(o_count), 32'd0);

    // single click
    do_reset(1'b0); clear_obs();
    hold(1'b1, 5); hold(1'b0, 10);
    check("t2_press", 32'(n_press), 32'd1);
    check("t2_release", 32'(n_release), 32'd1);
    check("t2_click", 32'(n_click), 32'd1);
    check("t2_click_delay", 32'(t_click - t_release), 32'd8);
    check("t2_no_dl", 32'(n_dclick + n_long), 32'd0);
    check("t2_count", 32'(o_count), 32'd1);

    // double click
    do_reset(1'b0); clear_obs();
    hold(1'b1, 4); hold(1'b0, 3); hold(1'b1, 4); hold(1'b0, 12);
    check("t3_dclick", 32'(n_dclick), 32'd1);
    check("t3_click", 32'(n_click), 32'd0);
    check("t3_count", 32'(o_count), 32'd2);

    // long press
    do_reset(1'b0); clear_obs();
    hold(1'b1, 30); hold(1'b0, 12);
    check("t4_long", 32'(n_long), 32'd1);
    check("t4_long_delay", 32'(t_long - t_press), 32'd16);
    check("t4_release", 32'(n_release), 32'd1);
    check("t4_no_click", 32'(n_click + n_dclick), 32'd0);
    check("t4_count", 32'(o_count), 32'd1);

    // release exactly at the long limit: click path wins
    do_reset(1'b0); clear_obs();
    hold(1'b1, 16); hold(1'b0, 12);
    check("t5a_long", 32'(n_long), 32'd0);
    check("t5a_click", 32'(n_click), 32'd1);

    // second press exactly at the double-click limit: press wins
    do_reset(1'b0); clear_obs();
    hold(1'b1, 3); hold(1'b0, 8); hold(1'b1, 3); hold(1'b0, 12);
    check("t5b_click", 32'(n_click), 32'd0);
    check("t5b_dclick", 32'(n_dclick), 32'd1);

    // counter wrap
    do_reset(1'b0); clear_obs();
    for (int p = 0; p < 256; p++) begin
      hold(1'b1, 2); hold(1'b0, 11);
    end
    check("t6_presses", 32'(n_press), 32'd256);
    check("t6_clicks", 32'(n_click), 32'd256);
    check("t6_wrap", 32'(o_count), 32'd0);

    // reset mid-press, button released during reset
    step(1'b1);
    do_reset(1'b0); clear_obs();
    hold(1'b0, 30);
    check("t6_post_rst_events", 32'(n_click + n_dclick + n_long + n_release), 32'd0);

    // button held through reset release reads as a fresh press
    step(1'b1);
    do_reset(1'b1); clear_obs();
    step(1'b1);
    check("t6_held_press", 32'(n_press), 32'd1);
    check("t6_held_count", 32'(o_count), 32'd1);
    hold(1'b0, 12);

    // randomized level segments with occasional resets
    lvl = 1'b0;
    for (int s = 0; s < 300; s++) begin
      lvl = ~lvl;
      case ($urandom_range(0, 3))
        0: dur = $urandom_range(1, 6);
        1: dur = $urandom_range(6, 10);
        2: dur = $urandom_range(14, 18);
        default: dur = $urandom_range(18, 25);
      endcase
      hold(lvl, dur);
      if ($urandom_range(0, 24) == 0) do_reset(lvl);
    end
    hold(1'b0, 30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
